lab3_cache_nway_tag_unit: RTL
=============================

// Module: lab3_cache_nway_tag_unit
// PURPOSE
//  Parametrised N-way set-associative tag/state unit for the write-back, write-allocate cache.
//  Holds tag, valid, dirty and true-LRU age state per (set, way) and performs registered lookups.
//  Picks the victim on a miss and accepts line fills. Runs a write-back flush walker that emits every dirty line.
//  Sits between the cache control FSM and the data array / mem sender.
// PARAMETERS
//  p_num_ways     4   ways per set; power of 2, 2..8; W = log2(p_num_ways)
//  p_num_sets     16  sets; power of 2, >=2; S = log2(p_num_sets)
//  p_line_nbytes  64  bytes per line; O = log2(p_line_nbytes)
//  tag width T = 32 - S - O (derived localparam, not overridable)
// PORTS
//  clk               in   1   clock
//  reset             in   1   sync active-high reset
//  req_val/req_rdy   in/out 1 lookup request handshake
//  req_addr          in   32  lookup byte address
//  req_write         in   1   lookup is a store: on hit set dirty
//  resp_val/resp_rdy out/in 1 lookup response handshake
//  resp_hit          out  1   tag matched a valid way
//  resp_way          out  W   hit way (valid when resp_hit)
//  resp_victim_way   out  W   replacement way (valid when !resp_hit)
//  resp_victim_dirty out  1   victim is valid and dirty
//  resp_victim_addr  out  32  {victim tag, set, O'b0}
//  fill_en           in   1   install line this cycle
//  fill_addr         in   32  line address being installed
//  fill_way          in   W   way to install into
//  fill_dirty        in   1   dirty value written with the fill
//  flush_val/flush_rdy in/out 1 start write-back flush
//  wb_val/wb_rdy     out/in 1 dirty line write-back handshake
//  wb_addr           out  32  {tag, set, O'b0} of the dirty line
//  flush_done        out  1   one-cycle pulse when flush completes
// BEHAVIOUR
//  Reset: all valid=0, dirty=0, age[set][w]=w; FSM=IDLE. All outputs are 0 and rdy outputs are 0 in the reset cycle.
//  Address split: tag=addr[31:S+O], set=addr[S+O-1:O]; low O bits are ignored.
//  req_rdy = IDLE && !fill_en && (!resp_val || resp_rdy).
//  Lookup latency is 1 cycle: request accepted in cycle t, response registered and visible at t+1.
//  Response holds stable while resp_val && !resp_rdy.
//  Hit on accept: age update for way h, and dirty[h] set when req_write=1. Both are visible from t+1.
//  Miss on accept: no state change. The victim is the lowest-index invalid way, else the way with age p_num_ways-1.
//  LRU update on access to w: every way with age < age[w] increments; age[w]=0.
//  Fill: tag written, valid=1, dirty=fill_dirty, LRU update for fill_way; effective next cycle.
//  A fill in the same cycle as a would-be lookup wins; the lookup is stalled via req_rdy=0.
//  fill_en is ignored outside IDLE.
//  flush_rdy = IDLE && !resp_val && !fill_en.
//  FSM IDLE -> SCAN on flush_val && flush_rdy.
//  SCAN visits one (set, way) per cycle, ordered set-major then way ascending.
//  SCAN -> WB when the visited entry is valid && dirty.
//  WB asserts wb_val and holds wb_addr stable until wb_rdy. On handshake the entry's dirty bit is cleared and the FSM returns to SCAN at the next entry.
//  After the last entry (set S-1, way N-1), the FSM goes to DONE. flush_done=1 for one cycle, then IDLE.
//  Minimum flush time is p_num_sets*p_num_ways+1 cycles.
//  Flush keeps valid bits and LRU state; it does not invalidate.
//  req_rdy and flush_rdy are 0 outside IDLE.
//  Reset mid-flush or mid-response aborts immediately. All state returns to the reset values and no flush_done is issued.
// CONFIGURATION
//  LAB3_CACHE_TAG_PERF_CNT_EN defined: adds 32-bit outputs hit_count and miss_count.
//   Each increments on every accepted lookup by outcome, wraps at 2^32, and resets to 0.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// TESTING (defaults: 4 ways, 16 sets, 64B, T=22)
//  1 After reset, lookup 0x0000_1000 -> resp at t+1: hit=0, victim_way=0, victim_dirty=0.
//  2 Fill 0x000/0x400/0x800/0xC00 into ways 0..3 (set 0), then hits on 0x000 and 0x400 -> resp_way 0,1.
//    Then lookup 0x1000 -> miss, victim_way=2, victim_addr=0x0000_0800.
//  3 Write-hit 0xC04 (way3), hits on 0x000/0x400/0x800, lookup 0x1000.
//    -> victim_way=3, victim_dirty=1, victim_addr=0x0000_0C00.
//  4 Dirty lines at set0/way3 (0xC00) and set5/way1 (0x540) -> flush gives wb_addr 0x0000_0C00 then 0x0000_0540.
//    flush_done follows, and later lookups of both hit.
//  5 Hold wb_rdy=0 for 10 cycles during WB, and hold resp_rdy=0 for 5 cycles on a response.
//    -> wb_addr and resp fields stay stable; req_rdy=0 throughout.
//  6 Assert reset in the SCAN/WB state -> next cycle IDLE with no flush_done.
//    A lookup of a previously filled address misses; with LAB3_CACHE_TAG_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/lab3_cache_nway_tag_unit_if.sv
// Purpose: bundles the lookup, fill, flush and write-back signals of the cache tag unit.
// Latency: none, wiring only.
// Backpressure: valid/ready pairs on lookup request, lookup response, flush start and write-back.
interface lab3_cache_nway_tag_unit_if #(
    parameter int p_way_w = 2
);
    logic               req_val;
    logic               req_rdy;
    logic [31:0]        req_addr;
    logic               req_write;

    logic               resp_val;
    logic               resp_rdy;
    logic               resp_hit;
    logic [p_way_w-1:0] resp_way;
    logic [p_way_w-1:0] resp_victim_way;
    logic               resp_victim_dirty;
    logic [31:0]        resp_victim_addr;

    logic               fill_en;
    logic [31:0]        fill_addr;
    logic [p_way_w-1:0] fill_way;
    logic               fill_dirty;

    logic               flush_val;
    logic               flush_rdy;
    logic               wb_val;
    logic               wb_rdy;
    logic [31:0]        wb_addr;
    logic               flush_done;

    // Cache control side: issues lookups, fills and flushes, consumes responses and write-backs.
    modport master (
        output req_val, req_addr, req_write, resp_rdy,
        output fill_en, fill_addr, fill_way, fill_dirty,
        output flush_val, wb_rdy,
        input  req_rdy, resp_val, resp_hit, resp_way, resp_victim_way,
        input  resp_victim_dirty, resp_victim_addr,
        input  flush_rdy, wb_val, wb_addr, flush_done
    );

    // Tag unit side.
    modport slave (
        input  req_val, req_addr, req_write, resp_rdy,
        input  fill_en, fill_addr, fill_way, fill_dirty,
        input  flush_val, wb_rdy,
        output req_rdy, resp_val, resp_hit, resp_way, resp_victim_way,
        output resp_victim_dirty, resp_victim_addr,
        output flush_rdy, wb_val, wb_addr, flush_done
    );
endinterface

// File: rtl/lab3_cache_nway_tag_unit.sv
// Purpose: N-way set-associative tag/valid/dirty/true-LRU store with victim select, fills and a dirty-line flush walker.
// Latency: lookup response registered 1 cycle after accept; flush walks one (set, way) per cycle.
// Backpressure: req_rdy drops while a response is held, during a fill, or outside IDLE; wb_addr holds until wb_rdy.
// Optional: define LAB3_CACHE_TAG_PERF_CNT_EN to add 32-bit hit_count / miss_count outputs.
module lab3_cache_nway_tag_unit #(
    parameter int p_num_ways    = 4,
    parameter int p_num_sets    = 16,
    parameter int p_line_nbytes = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    lab3_cache_nway_tag_unit_if.slave   bus
`ifdef LAB3_CACHE_TAG_PERF_CNT_EN
    ,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
`endif
);

    localparam int W = $clog2(p_num_ways);
    localparam int S = $clog2(p_num_sets);
    localparam int O = $clog2(p_line_nbytes);
    localparam int T = 32 - S - O;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Per-entry state
    logic [T-1:0]            tag_q   [p_num_sets][p_num_ways];
    logic [W-1:0]            age_q   [p_num_sets][p_num_ways];
    logic [p_num_ways-1:0]   valid_q [p_num_sets];
    logic [p_num_ways-1:0]   dirty_q [p_num_sets];

    // Registered lookup response
    logic                    resp_val_q;
    logic                    resp_hit_q;
    logic [W-1:0]            resp_way_q;
    logic [W-1:0]            resp_victim_way_q;
    logic                    resp_victim_dirty_q;
    logic [31:0]             resp_victim_addr_q;

    // Flush walker position: set in the upper bits, way in the lower bits, so +1 walks set-major
    logic [S+W-1:0]          scan_idx_q;
    logic [S-1:0]            scan_set;
    logic [W-1:0]            scan_way;
    logic                    scan_last;
    logic                    scan_dirty;
    logic                    scan_adv;

    // Address split for lookups and fills; line offset bits are dropped
    logic [T-1:0]            req_tag;
    logic [S-1:0]            req_set;
    logic [T-1:0]            fill_tag;
    logic [S-1:0]            fill_set;
    logic                    unused_offset;

    assign req_tag       = bus.req_addr[31:S+O];
    assign req_set       = bus.req_addr[S+O-1:O];
    assign fill_tag      = bus.fill_addr[31:S+O];
    assign fill_set      = bus.fill_addr[S+O-1:O];
    assign unused_offset = ^{bus.req_addr[O-1:0], bus.fill_addr[O-1:0]};

    assign scan_set   = scan_idx_q[S+W-1:W];
    assign scan_way   = scan_idx_q[W-1:0];
    assign scan_last  = &scan_idx_q;
    assign scan_dirty = valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way];

    // Handshake qualifiers; a fill always takes priority over a lookup in the same cycle
    logic is_idle;
    logic req_rdy_int;
    logic flush_rdy_int;
    logic req_fire;
    logic fill_fire;
    logic flush_fire;
    logic wb_fire;

    assign is_idle       = (state_q == IDLE);
    assign req_rdy_int   = !reset && is_idle && !bus.fill_en && (!resp_val_q || bus.resp_rdy);
    assign flush_rdy_int = !reset && is_idle && !resp_val_q && !bus.fill_en;
    assign req_fire      = bus.req_val && req_rdy_int;
    assign fill_fire     = bus.fill_en && is_idle && !reset;
    assign flush_fire    = bus.flush_val && flush_rdy_int;
    assign wb_fire       = (state_q == WB) && bus.wb_rdy;

    // Tag compare and victim selection for the addressed set
    logic            hit;
    logic [W-1:0]    hit_way;
    logic            inv_found;
    logic [W-1:0]    inv_way;
    logic [W-1:0]    lru_way;
    logic [W-1:0]    victim_way;
    logic            victim_dirty;
    logic [31:0]     victim_addr;

    // Lookup: first matching valid way; victim is lowest invalid way, else the oldest
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int i = 0; i < p_num_ways; i++) begin
            if (valid_q[req_set][i] && (tag_q[req_set][i] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = W'(i);
            end
            if (!valid_q[req_set][i] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = W'(i);
            end
            if (age_q[req_set][i] == W'(p_num_ways - 1)) begin
                lru_way = W'(i);
            end
        end
        victim_way   = inv_found ? inv_way : lru_way;
        victim_dirty = valid_q[req_set][victim_way] && dirty_q[req_set][victim_way];
        victim_addr  = {tag_q[req_set][victim_way], req_set, {O{1'b0}}};
    end

    // One LRU touch per cycle at most: a hitting lookup or a fill
    logic            touch_en;
    logic [S-1:0]    touch_set;
    logic [W-1:0]    touch_way;

    assign touch_en  = fill_fire || (req_fire && hit);
    assign touch_set = fill_fire ? fill_set : req_set;
    assign touch_way = fill_fire ? bus.fill_way : hit_way;

    // Flush FSM next-state: SCAN visits one entry per cycle, WB parks on a dirty entry until wb_rdy
    always_comb begin
        state_d  = state_q;
        scan_adv = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_fire) state_d = SCAN;
            end
            SCAN: begin
                if (scan_dirty) begin
                    state_d = WB;
                end else if (scan_last) begin
                    state_d = DONE;
                end else begin
                    scan_adv = 1'b1;
                end
            end
            WB: begin
                if (bus.wb_rdy) begin
                    if (scan_last) begin
                        state_d = DONE;
                    end else begin
                        state_d  = SCAN;
                        scan_adv = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Flush walker index: restarts at entry 0 on every flush
    always_ff @(posedge clk) begin
        if (reset)           scan_idx_q <= '0;
        else if (flush_fire) scan_idx_q <= '0;
        else if (scan_adv)   scan_idx_q <= scan_idx_q + 1'b1;
    end

    // Tag/valid/dirty/age arrays: fills, store hits, write-back clears and LRU aging
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < p_num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < p_num_ways; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= W'(w);
                end
            end
        end else begin
            if (fill_fire) begin
                tag_q[fill_set][bus.fill_way]   <= fill_tag;
                valid_q[fill_set][bus.fill_way] <= 1'b1;
                dirty_q[fill_set][bus.fill_way] <= bus.fill_dirty;
            end
            if (req_fire && hit && bus.req_write) begin
                dirty_q[req_set][hit_way] <= 1'b1;
            end
            if (wb_fire) begin
                dirty_q[scan_set][scan_way] <= 1'b0;
            end
            if (touch_en) begin
                for (int w = 0; w < p_num_ways; w++) begin
                    if (W'(w) == touch_way) begin
                        age_q[touch_set][w] <= '0;
                    end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                        age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
                    end
                end
            end
        end
    end

    // Response register: loads on accept, clears when consumed, holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_val_q          <= 1'b0;
            resp_hit_q          <= 1'b0;
            resp_way_q          <= '0;
            resp_victim_way_q   <= '0;
            resp_victim_dirty_q <= 1'b0;
            resp_victim_addr_q  <= '0;
        end else if (req_fire) begin
            resp_val_q          <= 1'b1;
            resp_hit_q          <= hit;
            resp_way_q          <= hit_way;
            resp_victim_way_q   <= victim_way;
            resp_victim_dirty_q <= victim_dirty;
            resp_victim_addr_q  <= victim_addr;
        end else if (bus.resp_rdy) begin
            resp_val_q          <= 1'b0;
        end
    end

`ifdef LAB3_CACHE_TAG_PERF_CNT_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Accepted-lookup counters by outcome, free-running with natural wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (req_fire) begin
            if (hit) hit_count_q  <= hit_count_q + 32'd1;
            else     miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = reset ? 32'd0 : hit_count_q;
    assign miss_count = reset ? 32'd0 : miss_count_q;
`endif

    // Outputs are forced to zero while reset is asserted so nothing stale leaks in that cycle
    assign bus.req_rdy           = req_rdy_int;
    assign bus.flush_rdy         = flush_rdy_int;
    assign bus.resp_val          = !reset && resp_val_q;
    assign bus.resp_hit          = !reset && resp_hit_q;
    assign bus.resp_way          = reset ? '0 : resp_way_q;
    assign bus.resp_victim_way   = reset ? '0 : resp_victim_way_q;
    assign bus.resp_victim_dirty = !reset && resp_victim_dirty_q;
    assign bus.resp_victim_addr  = reset ? 32'd0 : resp_victim_addr_q;
    assign bus.wb_val            = !reset && (state_q == WB);
    assign bus.wb_addr           = (!reset && (state_q == WB))
                                   ? {tag_q[scan_set][scan_way], scan_set, {O{1'b0}}} : 32'd0;
    assign bus.flush_done        = !reset && (state_q == DONE);

endmodule
